// File: rtl/ro_odometer_pkg.sv
// ---------------------------------------------------------------------------
// ro_odometer_pkg
// Shared types and defaults for the ring-oscillator odometer counter.
//   state_t  : measurement FSM encoding (IDLE, SETTLE, COUNT, DRAIN, DONE)
//   DEF_*    : default parameter values used by the top and sub-module
//   sat_inc  : saturating increment helper (operates on a 32-bit container)
// ---------------------------------------------------------------------------
package ro_odometer_pkg;

  localparam int DEF_CNT_W         = 16;
  localparam int DEF_GATE_W        = 16;
  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_SYNC_STAGES   = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_COUNT  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Increment val by one, but never past max_val.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// ---------------------------------------------------------------------------
// ro_sync_edge
// SYNC_STAGES-deep synchronizer for the asynchronous oscillator output plus a
// rising-edge detector on the synchronized value.
// Ports:
//   i_clk    : system clock
//   i_rst_n  : synchronous active-low reset (clears the chain)
//   i_en     : chain is held clear while low (oscillator disabled)
//   i_async  : raw oscillator output
//   o_rise   : 1 in each cycle where the chain shows a 0->1 transition
// ---------------------------------------------------------------------------
module ro_sync_edge
  import ro_odometer_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_async,
  output logic o_rise
);

  // r_sync[0] is the first flop; r_sync[SYNC_STAGES-1] is the oldest sample.
  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_en) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  // Newer sample high, older sample low: a rising edge passing down the chain.
  assign o_rise = r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ro_odometer_counter.sv
// ---------------------------------------------------------------------------
// ro_odometer_counter
// Enables the ring oscillator, lets it settle, counts rising edges of its
// output over a programmable window of clk cycles, then latches the result
// as an odometer reading.
// Optional feature macro: RO_ODO_DELTA_EN (adds enrolment base and delta).
// Ports:
//   i_clk, i_rst_n   : clock, synchronous active-low reset
//   i_start          : one-cycle measurement request (accepted only in IDLE)
//   i_abort          : cancel a measurement in SETTLE/COUNT/DRAIN
//   i_gate_len       : window length in clk cycles, sampled on accepted start
//   i_ro_out         : asynchronous oscillator output
//   i_capture_base   : (RO_ODO_DELTA_EN) copy o_count into o_base
//   o_en_ro          : registered oscillator enable
//   o_busy           : high from accepted start until done or abort
//   o_done           : one-cycle pulse, o_count/o_overflow valid
//   o_count          : last completed measurement
//   o_overflow       : last measurement saturated
//   o_base, o_delta  : (RO_ODO_DELTA_EN) enrolment reading, count - base
//   o_state          : current FSM state (debug)
// Handshake: i_start is a single-cycle request with no ready; it is taken only
// when o_state is IDLE and i_abort is low, otherwise dropped. Completion is
// signalled by the o_done pulse; there is no backpressure on the result.
// ---------------------------------------------------------------------------
module ro_odometer_counter
  import ro_odometer_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int GATE_W        = DEF_GATE_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [GATE_W-1:0]       i_gate_len,
  input  logic                    i_ro_out,
`ifdef RO_ODO_DELTA_EN
  input  logic                    i_capture_base,
  output logic [CNT_W-1:0]        o_base,
  output logic signed [CNT_W-1:0] o_delta,
`endif
  output logic                    o_en_ro,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [CNT_W-1:0]        o_count,
  output logic                    o_overflow,
  output state_t                  o_state
);

  // One timer serves settle, gate and drain phases.
  localparam int TMR_W = (GATE_W > 8) ? GATE_W : 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             r_state;
  logic [TMR_W-1:0]   r_tmr;
  logic [GATE_W-1:0]  r_gate_m1;
  logic [CNT_W-1:0]   r_edge_cnt;
  logic               r_ovf;
  logic               r_en_ro;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
  logic               w_rise;
  logic [CNT_W-1:0]   w_cnt_inc;

  ro_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (r_en_ro),
    .i_async(i_ro_out),
    .o_rise (w_rise)
  );

  assign w_cnt_inc = CNT_W'(sat_inc(32'(r_edge_cnt), 32'(CNT_MAX)));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_tmr      <= '0;
      r_gate_m1  <= '0;
      r_edge_cnt <= '0;
      r_ovf      <= 1'b0;
      r_en_ro    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_abort) begin
            r_state   <= ST_SETTLE;
            r_en_ro   <= 1'b1;
            r_busy    <= 1'b1;
            // A zero window is run as a one-cycle window.
            r_gate_m1 <= (i_gate_len == '0) ? '0 : i_gate_len - GATE_W'(1);
            r_tmr     <= TMR_W'(SETTLE_CYCLES - 1);
          end
        end
        ST_SETTLE: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
            r_en_ro <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_tmr == '0) begin
            r_state    <= ST_COUNT;
            r_tmr      <= TMR_W'(r_gate_m1);
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        ST_COUNT: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
            r_en_ro <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            if (w_rise) begin
              r_edge_cnt <= w_cnt_inc;
              // Overflow means an edge arrived that could not be counted.
              if (r_edge_cnt == CNT_MAX) r_ovf <= 1'b1;
            end
            if (r_tmr == '0) begin
              r_state <= ST_DRAIN;
              r_en_ro <= 1'b0;
              r_tmr   <= TMR_W'(SYNC_STAGES - 1);
            end else begin
              r_tmr <= r_tmr - TMR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          // en_ro is low here, so the synchronizer is being flushed.
          if (i_abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_tmr == '0) begin
            r_state    <= ST_DONE;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_count    <= r_edge_cnt;
            r_overflow <= r_ovf;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_en_ro <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_en_ro    = r_en_ro;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_state    = r_state;

`ifdef RO_ODO_DELTA_EN
  logic [CNT_W-1:0]        r_base;
  logic signed [CNT_W-1:0] r_delta;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_base  <= '0;
      r_delta <= '0;
    end else begin
      if (i_capture_base) r_base <= r_count;
      // Drift against the enrolment reading; lags count/base by one cycle.
      r_delta <= signed'(r_count - r_base);
    end
  end

  assign o_base  = r_base;
  assign o_delta = r_delta;
`endif

endmodule

// File: doc/ro_odometer_counter.md
Name: ro_odometer_counter

Overview:
- Measurement stage directly downstream of ring_oscillator.
- Drives the oscillator's en_ro and counts rising edges of its ro_out over a programmable window of clk cycles.
- Latches the result as an odometer reading for the security engine's aging/tamper logic.
- Single clock domain: ro_out is treated as an asynchronous input, synchronized and edge-detected inside the block.

Parameters:
- CNT_W, 16, width of edge counter and result.
- GATE_W, 16, width of gate_len input.
- SETTLE_CYCLES, 8, clk cycles with en_ro high before counting starts (oscillator start-up); legal range 1..255.
- SYNC_STAGES, 2, synchronizer flops on ro_out; minimum 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a measurement.
- abort  in  1  cancel the measurement in progress.
- gate_len  in  GATE_W  counting window in clk cycles; sampled on accepted start.
- ro_out  in  1  oscillator output (asynchronous).
- en_ro  out  1  oscillator enable.
- busy  out  1  high from accepted start until done or abort.
- done  out  1  one-cycle pulse when result is valid.
- count  out  CNT_W  last completed measurement; held until next done.
- overflow  out  1  last measurement saturated; updated with count.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state IDLE.
  - en_ro=0, busy=0, done=0, count=0, overflow=0.
  - Synchronizer flops and edge counter cleared.
- IDLE:
  - start=1 moves to SETTLE next cycle.
  - gate_len is latched; gate_len==0 is treated as 1.
  - en_ro and busy rise in the cycle after start.
- SETTLE:
  - en_ro=1; runs for exactly SETTLE_CYCLES cycles; no edges counted.
  - Then moves to COUNT and clears the edge counter.
- COUNT:
  - Lasts exactly latched gate_len cycles.
  - Each cycle in which the synchronized ro_out shows a 0->1 transition (sync[N-1]=0, sync[N-2]=1) increments the counter by 1.
  - The counter saturates at 2^CNT_W-1 and sets an internal ovf flag.
  - After the last gate cycle, moves to DRAIN.
- DRAIN:
  - en_ro=0; lasts SYNC_STAGES cycles; edges are not counted.
  - Flushes the synchronizer so the next run does not see stale edges.
  - Then moves to DONE.
- DONE (one cycle):
  - count <= edge counter and overflow <= ovf, both registered.
  - done=1 and busy=0 in this same cycle.
  - Returns to IDLE next.
- Latency from start to done: 1 + SETTLE_CYCLES + gate_len + SYNC_STAGES cycles.
- start while busy is ignored; no queuing.
- start and abort in the same IDLE cycle: abort wins, nothing starts.
- abort in SETTLE, COUNT or DRAIN:
  - Next cycle: IDLE, en_ro=0, busy=0.
  - No done; count and overflow keep their previous values.
- abort in DONE or IDLE has no effect.
- Reset mid-measurement behaves as abort and also clears count and overflow.
- Accuracy rule: the ro_out frequency must be below clk/2; faster inputs alias. A low-frequency divider is the integrator's responsibility.
- en_ro is a registered output; no glitches.

Optional Feature:
- Macro RO_ODO_DELTA_EN.
- When defined:
  - Adds input capture_base (1) and outputs base (CNT_W) and delta (CNT_W, signed two's-complement).
  - capture_base=1 in the DONE cycle, or any later cycle, copies count into base.
  - delta = count - base, registered, updated one cycle after count or base changes.
  - base and delta reset to 0.
  - Measures oscillator aging drift against an enrolment reading.
- When undefined: none of these ports or registers exist; behaviour is otherwise identical.

Decomposition:
- Package ro_odometer_pkg holds:
  - state enum (IDLE, SETTLE, COUNT, DRAIN, DONE).
  - default widths.
  - function for saturating increment.
- One sub-module, ro_sync_edge:
  - SYNC_STAGES-deep synchronizer on ro_out plus rising-edge pulse output.
  - Cleared by rst_n and held clear while en_ro=0.
- The FSM, gate counter and edge counter live in ro_odometer_counter.

Test Plan:
- Basic count:
  - Reset, then SETTLE_CYCLES=8, gate_len=60; bench toggles ro_out every 3 clk cycles (period 6).
  - Required: done exactly 1+8+60+2=71 cycles after start; count=10 ±1; overflow=0; en_ro high only during SETTLE and COUNT.
- Saturation:
  - CNT_W=4, gate_len=100, ro_out period 4.
  - Required: count=15, overflow=1.
  - A following run with gate_len=8 gives count=2 ±1, overflow=0.
- Abort:
  - start, then abort 20 cycles later in COUNT.
  - Required: en_ro=0 and busy=0 next cycle; no done; count keeps its previous value (10).
- Start while busy, start+abort, and gate_len=0:
  - start pulses during COUNT are ignored and latency is unchanged.
  - start+abort together in IDLE: busy stays 0.
  - gate_len=0 behaves as gate_len=1.
- Mid-run reset:
  - rst_n low for 1 cycle during SETTLE.
  - Required: all outputs 0 next cycle; a new start then completes normally.
- RO_ODO_DELTA_EN:
  - Run A (count 10), then capture_base; run B with ro_out period 5 over 60 cycles.
  - Required: base=10, delta=+2 ±1.
